rr_arb4_ctrl: RTL and testbench



---
 rtl/rr_arb4_ctrl_if.sv | 31 +++
 rtl/rr_arb4_ctrl.sv | 103 ++++++++++
 tb/tb_rr_arb4_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_arb4_ctrl_if.sv
// rtl/rr_arb4_ctrl_if.sv - request/grant bundle between requesters and the round-robin arbiter
interface rr_arb4_ctrl_if #(
  parameter int CNT_W = 5
) ();
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       gnt_idx;
  logic             gnt_vld;
  logic             preempt;
  logic [CNT_W-1:0] hold_cnt;

  // requester side: drives requests, observes grants
  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld,
    input  preempt,
    input  hold_cnt
  );

  // arbiter side
  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_vld,
    output preempt,
    output hold_cnt
  );
endinterface

// File: rtl/rr_arb4_ctrl.sv
// rtl/rr_arb4_ctrl.sv - 4-way round-robin arbiter with registered grant and hold timeout
module rr_arb4_ctrl #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arb4_ctrl_if.slave bus_if
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // hold_cnt value on the last grant cycle an owner may keep while others wait
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam bit               TMO_EN    = (MAX_HOLD > 0);

  state_t           state_q;
  logic [1:0]       last_q;
  logic [3:0]       gnt_q;
  logic [1:0]       idx_q;
  logic             vld_q;
  logic             pre_q;
  logic [CNT_W-1:0] hold_q;

  logic [1:0]       win_d;
  logic             owner_req;
  logic             others_wait;
  logic             timeout_hit;

  // pick the first requester after the last owner, wrapping around
  always_comb begin
    logic       found;
    logic [1:0] cand;
    win_d = last_q;
    found = 1'b0;
    cand  = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && bus_if.req[cand]) begin
        win_d = cand;
        found = 1'b1;
      end
    end
  end

  // owner status derived from the live request lines and the current one-hot grant
  always_comb begin
    owner_req   = |(bus_if.req & gnt_q);
    others_wait = |(bus_if.req & ~gnt_q);
    timeout_hit = TMO_EN && (hold_q == HOLD_LAST) && others_wait;
  end

  // arbitration FSM with registered outputs; pointer keeps the last owner so it
  // ends up with the lowest priority on the next round
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'b00;
      vld_q   <= 1'b0;
      pre_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      pre_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|bus_if.req) begin
            gnt_q   <= 4'b0001 << win_d;
            idx_q   <= win_d;
            vld_q   <= 1'b1;
            last_q  <= win_d;
            hold_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req || timeout_hit) begin
            gnt_q   <= 4'b0000;
            idx_q   <= 2'b00;
            vld_q   <= 1'b0;
            hold_q  <= '0;
            pre_q   <= owner_req;
            state_q <= IDLE;
          end else if (hold_q != {CNT_W{1'b1}}) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.gnt      = gnt_q;
  assign bus_if.gnt_idx  = idx_q;
  assign bus_if.gnt_vld  = vld_q;
  assign bus_if.preempt  = pre_q;
  assign bus_if.hold_cnt = hold_q;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// tb/tb_rr_arb4_ctrl.sv - randomized and directed checks of rr_arb4_ctrl against a behavioural model
module tb_rr_arb4_ctrl;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 5;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rr_arb4_ctrl_if #(.CNT_W(CNT_W)) bus ();

  rr_arb4_ctrl #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: who owns the resource, who owned it last, how long held
  int m_owner;
  int m_last;
  int m_held;
  bit m_pre;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_last  = 3;
      m_held  = 0;
      m_pre   = 0;
    end else begin
      m_pre = 0;
      if (m_owner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_owner < 0 && bus.req[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
        end
        if (m_owner >= 0) begin
          m_last = m_owner;
          m_held = 0;
        end
      end else if (!bus.req[m_owner]) begin
        m_owner = -1;
        m_held  = 0;
      end else if (MAX_HOLD > 0 && m_held == MAX_HOLD - 1 &&
                   (bus.req & ~(4'b0001 << m_owner)) != 4'b0000) begin
        m_owner = -1;
        m_held  = 0;
        m_pre   = 1;
      end else if (m_held < SAT) begin
        m_held = m_held + 1;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("gnt",      int'(bus.gnt),      (m_owner >= 0) ? (1 << m_owner) : 0);
    chk("gnt_idx",  int'(bus.gnt_idx),  (m_owner >= 0) ? m_owner : 0);
    chk("gnt_vld",  int'(bus.gnt_vld),  (m_owner >= 0) ? 1 : 0);
    chk("preempt",  int'(bus.preempt),  int'(m_pre));
    chk("hold_cnt", int'(bus.hold_cnt), m_held);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    rst_n   = 1'b0;
    #2;
    rst_n   = 1'b1;
  endtask

  initial begin
    int o;
    total   = 0;
    bad     = 0;
    bus.req = 4'b0000;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt",  int'(bus.gnt),      0);
    chk("rst_idx",  int'(bus.gnt_idx),  0);
    chk("rst_vld",  int'(bus.gnt_vld),  0);
    chk("rst_pre",  int'(bus.preempt),  0);
    chk("rst_hold", int'(bus.hold_cnt), 0);
    cyc();
    rst_n = 1'b1;

    // single requester: one-cycle grant latency, release on drop
    bus.req = 4'b0001;
    cyc();
    chk("s1_gnt", int'(bus.gnt), 1);
    chk("s1_idx", int'(bus.gnt_idx), 0);
    chk("s1_vld", int'(bus.gnt_vld), 1);
    bus.req = 4'b0000;
    cyc();
    chk("s1_rel_gnt", int'(bus.gnt), 0);
    chk("s1_rel_vld", int'(bus.gnt_vld), 0);

    // all requesting, each owner drops after 3 grant cycles: 0,1,2,3,0
    cyc();
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      o = i % 4;
      cyc();
      chk("rr_idx", int'(bus.gnt_idx), o);
      chk("rr_gnt", int'(bus.gnt), 1 << o);
      cyc();
      cyc();
      bus.req[o] = 1'b0;
      cyc();
      chk("rr_gap", int'(bus.gnt), 0);
      bus.req[o] = 1'b1;
    end

    // timeout preemption of owner 2 by waiting requester 0
    cyc();
    do_reset();
    bus.req = 4'b0100;
    cyc();
    chk("pe_own2", int'(bus.gnt), 4);
    bus.req = 4'b0101;
    cyc();
    cyc();
    cyc();
    cyc();
    chk("pe_gnt0", int'(bus.gnt), 0);
    chk("pe_pulse", int'(bus.preempt), 1);
    cyc();
    chk("pe_next", int'(bus.gnt), 1);
    chk("pe_pulse_end", int'(bus.preempt), 0);
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (bus.gnt_vld && bus.gnt != 4'b0001) break;
    end
    chk("pe_back_to_2", int'(bus.gnt), 4);
    bus.req = 4'b0000;

    // lone owner never preempted, hold counter saturates
    cyc();
    do_reset();
    bus.req = 4'b1000;
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("solo_gnt", int'(bus.gnt), 8);
      chk("solo_pre", int'(bus.preempt), 0);
    end
    chk("solo_sat", int'(bus.hold_cnt), 31);

    // wrap search from last owner 1, then from last owner 0
    cyc();
    do_reset();
    bus.req = 4'b0010;
    cyc();
    bus.req = 4'b0000;
    cyc();
    bus.req = 4'b0011;
    cyc();
    chk("wrap_l1", int'(bus.gnt), 1);
    bus.req = 4'b0000;
    cyc();
    bus.req = 4'b0011;
    cyc();
    chk("wrap_l0", int'(bus.gnt), 2);

    // asynchronous reset in the middle of a grant
    cyc();
    do_reset();
    bus.req = 4'b0100;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("ar_gnt",  int'(bus.gnt), 0);
    chk("ar_hold", int'(bus.hold_cnt), 0);
    chk("ar_vld",  int'(bus.gnt_vld), 0);
    #1 rst_n = 1'b1;
    bus.req = 4'b0101;
    cyc();
    chk("ar_after", int'(bus.gnt), 1);

    // randomized request traffic, checked every cycle by the compare process
    cyc();
    do_reset();
    bus.req = 4'($urandom_range(0, 15));
    for (int i = 0; i < 600; i++) begin
      cyc();
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 4) == 0) bus.req[b] = ~bus.req[b];
      end
    end

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
